// File: rtl/pc_gen_mc_if.sv
// rtl/pc_gen_mc_if.sv - fetch PC generator bus: decoder, CDB, ROB, staller in; icache controls out.
interface pc_gen_mc_if #(
  parameter int ADDR_W  = 32,
  parameter int LOCK_W  = 5,
  parameter int NUM_CDB = 2
);
  logic                        ce;
  logic [ADDR_W-1:0]           pc;
  logic                        flush;
  logic                        pc_locked;

  logic                        dec_valid;
  logic [LOCK_W-1:0]           dec_lock;
  logic [ADDR_W-1:0]           dec_offset;

  logic [NUM_CDB-1:0]          cdb_valid;
  logic [NUM_CDB*LOCK_W-1:0]   cdb_index;
  logic [NUM_CDB*ADDR_W-1:0]   cdb_result;

  logic                        rob_modify;
  logic [ADDR_W-1:0]           rob_npc;

  logic                        stall;

  // master drives the pipeline-side inputs and observes the fetch outputs
  modport master (
    input  ce, pc, flush, pc_locked,
    output dec_valid, dec_lock, dec_offset,
    output cdb_valid, cdb_index, cdb_result,
    output rob_modify, rob_npc, stall
  );

  modport slave (
    output ce, pc, flush, pc_locked,
    input  dec_valid, dec_lock, dec_offset,
    input  cdb_valid, cdb_index, cdb_result,
    input  rob_modify, rob_npc, stall
  );
endinterface

// File: rtl/pc_gen_mc.sv
// rtl/pc_gen_mc.sv - fetch address generator with decoder locks, CDB resolve and ROB redirect.
module pc_gen_mc #(
  parameter int ADDR_W     = 32,
  parameter int LOCK_W     = 5,
  parameter int NO_LOCK    = 0,
  parameter int NUM_CDB    = 2,
  parameter int RESET_PC   = 0,
  parameter int INST_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_gen_mc_if.slave  bus
);

  localparam logic [LOCK_W-1:0] NO_TAG   = LOCK_W'(NO_LOCK);
  localparam logic [ADDR_W-1:0] BOOT_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] DEF_STEP = ADDR_W'(INST_BYTES);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ce_q, ce_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [ADDR_W-1:0] step_q, step_d;

  logic [LOCK_W-1:0] cdb_tag [NUM_CDB];
  logic [ADDR_W-1:0] cdb_res [NUM_CDB];

  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb
    assign cdb_tag[g] = bus.cdb_index[g*LOCK_W +: LOCK_W];
    assign cdb_res[g] = bus.cdb_result[g*ADDR_W +: ADDR_W];
  end

  // Two searches: one against the incoming decoder tag (same-cycle bypass),
  // one against the held tag. Scanning downward lets the lowest channel win.
  logic              dec_hit, held_hit;
  logic [ADDR_W-1:0] dec_hit_res, held_hit_res;

  always_comb begin
    dec_hit      = 1'b0;
    held_hit     = 1'b0;
    dec_hit_res  = '0;
    held_hit_res = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (bus.cdb_valid[i] && (cdb_tag[i] != NO_TAG)) begin
        if (cdb_tag[i] == bus.dec_lock) begin
          dec_hit     = 1'b1;
          dec_hit_res = cdb_res[i];
        end
        if (cdb_tag[i] == lock_q) begin
          held_hit     = 1'b1;
          held_hit_res = cdb_res[i];
        end
      end
    end
  end

  logic              lock_req;
  logic [ADDR_W-1:0] nstep;

  assign lock_req = bus.dec_valid && (bus.dec_lock != NO_TAG);
  assign nstep    = bus.dec_valid ? bus.dec_offset : step_q;

  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    flush_d = 1'b0;
    pc_d    = pc_q;
    lock_d  = lock_q;
    step_d  = step_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end

      RUN: begin
        if (bus.rob_modify) begin
          state_d = RUN;
          pc_d    = bus.rob_npc;
          lock_d  = NO_TAG;
          step_d  = DEF_STEP;
          flush_d = 1'b1;
        end else if (lock_req) begin
          if (dec_hit) begin
            lock_d = NO_TAG;
            step_d = dec_hit_res;
          end else begin
            lock_d  = bus.dec_lock;
            state_d = LOCKED;
          end
        end else if (!bus.stall) begin
          pc_d   = pc_q + nstep;
          step_d = DEF_STEP;
        end else if (bus.dec_valid) begin
          step_d = bus.dec_offset;
        end
      end

      LOCKED: begin
        if (bus.rob_modify) begin
          state_d = RUN;
          pc_d    = bus.rob_npc;
          lock_d  = NO_TAG;
          step_d  = DEF_STEP;
          flush_d = 1'b1;
        end else if (held_hit) begin
          state_d = RUN;
          lock_d  = NO_TAG;
          step_d  = held_hit_res;
        end
      end

      default: begin
        state_d = BOOT;
        ce_d    = 1'b0;
        pc_d    = BOOT_PC;
        lock_d  = NO_TAG;
        step_d  = DEF_STEP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      ce_q    <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= BOOT_PC;
      lock_q  <= NO_TAG;
      step_q  <= DEF_STEP;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
      lock_q  <= lock_d;
      step_q  <= step_d;
    end
  end

  assign bus.ce        = ce_q;
  assign bus.pc        = pc_q;
  assign bus.flush     = flush_q;
  assign bus.pc_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_pc_gen_mc.sv
// tb/tb_pc_gen_mc.sv - directed vectors with a queued scoreboard for pc_gen_mc.
module tb_pc_gen_mc;

  logic clk;
  logic rst;

  pc_gen_mc_if #(.ADDR_W(32), .LOCK_W(5), .NUM_CDB(2)) bus ();

  pc_gen_mc #(
    .ADDR_W(32), .LOCK_W(5), .NO_LOCK(0), .NUM_CDB(2), .RESET_PC(0), .INST_BYTES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        flush;
    logic        locked;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  // Inputs for one cycle are applied at negedge; the expectation is for
  // the outputs right after the following posedge.
  task automatic step(input logic r, input logic dv, input logic [4:0] dl, input logic [31:0] doff,
                      input logic [1:0] cv, input logic [4:0] i0, input logic [31:0] r0,
                      input logic [4:0] i1, input logic [31:0] r1,
                      input logic rob, input logic [31:0] npc, input logic st,
                      input logic e_ce, input logic [31:0] e_pc, input logic e_fl, input logic e_lk,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.dec_valid  = dv;
    bus.dec_lock   = dl;
    bus.dec_offset = doff;
    bus.cdb_valid  = cv;
    bus.cdb_index  = {i1, i0};
    bus.cdb_result = {r1, r0};
    bus.rob_modify = rob;
    bus.rob_npc    = npc;
    bus.stall      = st;
    e.ce     = e_ce;
    e.pc     = e_pc;
    e.flush  = e_fl;
    e.locked = e_lk;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.ce !== e.ce || bus.pc !== e.pc || bus.flush !== e.flush || bus.pc_locked !== e.locked) begin
          failures++;
          $display("FAIL %s: got ce=%0b pc=%h flush=%0b locked=%0b, want ce=%0b pc=%h flush=%0b locked=%0b",
                   nm, bus.ce, bus.pc, bus.flush, bus.pc_locked, e.ce, e.pc, e.flush, e.locked);
        end
      end
    end
  end

  initial begin : stimulus
    rst            = 1'b0;
    bus.dec_valid  = 1'b0;
    bus.dec_lock   = '0;
    bus.dec_offset = '0;
    bus.cdb_valid  = '0;
    bus.cdb_index  = '0;
    bus.cdb_result = '0;
    bus.rob_modify = 1'b0;
    bus.rob_npc    = '0;
    bus.stall      = 1'b0;

    //    r  dv dl doff          cv     i0 r0            i1 r1            rob npc          st   ce pc            fl lk
    step(0, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0000, 0, 0, "reset0");
    step(0, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0000, 0, 0, "reset1");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0000, 0, 0, "boot");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0004, 0, 0, "seq4");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0008, 0, 0, "seq8");
    step(1, 1, 0, 32'h20,       2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0028, 0, 0, "dec_off20");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_002C, 0, 0, "seq2c");
    step(1, 1, 0, 32'hFFFF_FFE4,2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, 0, "neg_off");
    step(1, 1, 3, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, 1, "lock3");
    step(1, 0, 0, 32'h0,        2'b01, 5, 32'h100,      0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, 1, "lock_wrongtag");
    step(1, 1, 0, 32'h50,       2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, 1, "lock_dec_ignored");
    step(1, 0, 0, 32'h0,        2'b11, 0, 32'h200,      0, 32'h300,      0, 32'h0,        0,   1, 32'h0000_0010, 0, 1, "lock_notag_bcast");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0010, 0, 1, "lock_stalled");
    step(1, 0, 0, 32'h0,        2'b10, 0, 32'h0,        3, 32'hFFFF_FFF0,0, 32'h0,        0,   1, 32'h0000_0010, 0, 0, "resolve_ch1");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0000, 0, 0, "wrap");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0004, 0, 0, "after_wrap");
    step(1, 1, 7, 32'h0,        2'b11, 7, 32'h40,       7, 32'h80,       0, 32'h0,        0,   1, 32'h0000_0004, 0, 0, "bypass");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0044, 0, 0, "bypass_step40");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0048, 0, 0, "bypass_after");
    step(1, 1, 9, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0048, 0, 1, "lock9");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h1000,     1,   1, 32'h0000_1000, 1, 0, "redirect");
    step(1, 0, 0, 32'h0,        2'b01, 9, 32'h200,      0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_1004, 0, 0, "stale_tag");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_1008, 0, 0, "post_redirect");
    step(1, 1, 0, 32'h8,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_1008, 0, 0, "stall_off8");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_1008, 0, 0, "stall_hold");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_1010, 0, 0, "stall_release");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_1014, 0, 0, "seq_after_stall");
    step(1, 1, 4, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_1014, 0, 1, "lock4");
    step(0, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0000, 0, 0, "reset_locked");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h2000,     0,   1, 32'h0000_0000, 0, 0, "boot_rob_ignored");
    step(1, 0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0004, 0, 0, "seq_after_reset");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_gen_mc.md
Name: pc_gen_mc

Overview:
- Parametrised fetch-address generator for the out-of-order core. Drives the icache enable and the fetch PC, and stalls fetch on unresolved control-flow locks from the decoder.
- Resolves a lock from any of NUM_CDB common-data-bus channels.
- Accepts ROB mispredict redirects, which take priority over both stall and lock.
- Sits between the decoder, CDB, ROB, staller and icache.

Parameters:
- ADDR_W, 32: instruction address width.
- LOCK_W, 5: ROB/lock tag width.
- NO_LOCK, 0: tag value meaning "no lock".
- NUM_CDB, 2: number of CDB broadcast channels, at least 1.
- RESET_PC, 0: first fetch address.
- INST_BYTES, 4: default sequential step.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-low reset.
- ce, out, 1: icache enable.
- pc, out, ADDR_W: current fetch address.
- flush, out, 1: one-cycle pulse after an accepted ROB redirect.
- dec_valid, in, 1: decoder result valid this cycle.
- dec_lock, in, LOCK_W: tag the next PC depends on; NO_LOCK means none.
- dec_offset, in, ADDR_W: PC step when not locked.
- cdb_valid, in, NUM_CDB: per-channel broadcast valid.
- cdb_index, in, NUM_CDB*LOCK_W: per-channel tag, channel i at bits [i*LOCK_W +: LOCK_W].
- cdb_result, in, NUM_CDB*ADDR_W: per-channel result, used as the PC step.
- rob_modify, in, 1: redirect request.
- rob_npc, in, ADDR_W: redirect target.
- stall, in, 1: staller hold.
- pc_locked, out, 1: waiting on a CDB tag.

Behaviour:
- States: BOOT, RUN, LOCKED. Internal registers lock_q (LOCK_W) and step_q (ADDR_W).
- Reset (rst==0 at posedge): state=BOOT, ce=0, pc=RESET_PC, flush=0, lock_q=NO_LOCK, step_q=INST_BYTES, pc_locked=0.
- All outputs are registered except pc_locked, which is defined as (state==LOCKED).
- BOOT: unconditionally goes to RUN next cycle, ce<=1, pc holds RESET_PC. ce stays 1 until the next reset.
- Redirect has highest priority in RUN and LOCKED:
  - On rob_modify=1: pc<=rob_npc, state<=RUN, lock_q<=NO_LOCK, step_q<=INST_BYTES, flush<=1 next cycle.
  - Applies regardless of stall, dec_valid or CDB.
  - rob_modify in BOOT is ignored.
- flush is 0 in every cycle not following an accepted redirect.
- RUN, decoder lock:
  - Condition: dec_valid=1 and dec_lock!=NO_LOCK. pc holds and lock_q<=dec_lock. Stall does not block lock capture.
  - Same-cycle bypass: if any channel has cdb_valid=1 and index==dec_lock, the lock resolves immediately. step_q<=result of the lowest matching channel; state stays RUN.
  - Otherwise state<=LOCKED.
- RUN, advance:
  - Condition: no lock request and stall=0.
  - pc<=pc+nstep, where nstep = dec_offset if dec_valid=1, else step_q. Then step_q<=INST_BYTES.
- RUN, stall=1 with no lock request:
  - pc holds.
  - If dec_valid, step_q<=dec_offset, so the offset is kept for the next advance.
- LOCKED:
  - pc holds; stall is irrelevant.
  - Match: cdb_valid[i]=1 and cdb_index_i==lock_q.
  - On a match, the lowest-index matching channel wins: step_q<=cdb_result_i, lock_q<=NO_LOCK, state<=RUN. The new PC is applied at the next unstalled RUN cycle.
  - dec_valid is ignored while LOCKED.
- CDB broadcasts carrying index NO_LOCK never match.
- Arithmetic is modulo 2^ADDR_W: pc+step wraps with no error, and a negative offset in two's complement moves backward.
- Reset mid-LOCKED or mid-stall discards lock and step and returns to BOOT.

Test Plan:
- Reset with rst=0 for 2 cycles, then 1 -> ce=0 and pc=0 during reset. ce=1 the cycle after BOOT. pc steps 0,4,8,12 on consecutive unstalled cycles.
- Decoder offset: at pc=8, dec_valid=1, dec_lock=0, dec_offset=0x20 -> pc=0x28, then 0x2C.
- Lock with late resolve:
  - At pc=0x10, dec_lock=3 -> pc_locked=1 next cycle and pc holds 0x10 for 5 cycles.
  - Then cdb_valid=2'b10, index1=3, result1=0xFFFFFFF0 -> pc_locked=0.
  - Next unstalled cycle pc=0x00000000 (wrap), then pc=4.
- Same-cycle bypass and priority:
  - dec_lock=7 while cdb ch0 and ch1 both broadcast tag 7 with results 0x40 and 0x80 -> pc_locked stays 0; next advance pc+=0x40.
- Redirect over stall and lock:
  - In LOCKED with stall=1, rob_modify=1, rob_npc=0x1000 -> pc=0x1000, pc_locked=0, flush=1 for exactly one cycle.
  - A later CDB broadcast of the old tag has no effect.
- Stall and reset:
  - stall=1 with dec_offset=0x8 -> pc holds; after stall drops, pc+=8.
  - Assert rst=0 while LOCKED -> pc=RESET_PC, pc_locked=0.
